sr04_distance_meter: RTL

Drives an HC-SR04 ultrasonic sensor and turns its echo pulse width into a distance in centimetres. It generates the trigger pulse and times the echo entirely in clk cycles. Its 14-bit result feeds directly into the 4-digit FND display controller's count input. Runs on the 100 MHz system clock.

---
 rtl/sr04_pkg.sv | 35 +++
 rtl/sr04_distance_meter_echo_sync.sv | 42 ++++
 rtl/sr04_distance_meter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sr04_pkg.sv
// Shared definitions for the HC-SR04 distance meter.
// Holds the FSM state encoding, the cycle counts at the default 100 MHz clock
// and the widths of the internal counters and of the distance result.
package sr04_pkg;

  // Default timing figures (100 MHz system clock).
  localparam int DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int DEF_TRIG_US     = 10;
  localparam int DEF_CM_US       = 58;
  localparam int DEF_TIMEOUT_US  = 30_000;
  localparam int DEF_HOLDOFF_US  = 60_000;
  localparam int DEF_DIST_MAX    = 9999;

  // Cycle counts derived from the defaults.
  localparam int CYC_PER_US  = DEF_CLK_FREQ_HZ / 1_000_000;
  localparam int TRIG_CYC    = DEF_TRIG_US * CYC_PER_US;
  localparam int CYC_PER_CM  = DEF_CM_US * CYC_PER_US;
  localparam int TIMEOUT_CYC = DEF_TIMEOUT_US * CYC_PER_US;
  localparam int HOLDOFF_CYC = DEF_HOLDOFF_US * CYC_PER_US;

  // Counter widths: 6,000,000 fits in 23 bits, 5,800 in 13 bits, 9,999 in 14 bits.
  localparam int CNT_W  = 23;
  localparam int CM_W   = 13;
  localparam int DIST_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_DONE      = 3'd4,
    ST_HOLDOFF   = 3'd5
  } state_t;

endpackage

// File: rtl/sr04_distance_meter_echo_sync.sv
// Echo input conditioning for the HC-SR04 meter.
// Two flip-flops bring the asynchronous echo pin into the clk domain; a third
// register holds the previous synchronised value so edges can be detected.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   echo       raw sensor echo pin
//   echo_s     synchronised echo level
//   echo_rise  one-cycle pulse on a synchronised rising edge
//   echo_fall  one-cycle pulse on a synchronised falling edge
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic echo_s,
  output logic echo_rise,
  output logic echo_fall
);

  logic meta_r;
  logic sync_r;
  logic dly_r;

  // Synchroniser chain plus one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      dly_r  <= 1'b0;
    end else begin
      meta_r <= echo;
      sync_r <= meta_r;
      dly_r  <= sync_r;
    end
  end

  // Edge pulses are visible two edges after the pin moves, so the FSM acts on
  // the third edge; the same latency applies to both edges.
  assign echo_s    = sync_r;
  assign echo_rise = sync_r & ~dly_r;
  assign echo_fall = ~sync_r & dly_r;

endmodule

// File: rtl/sr04_distance_meter.sv
// HC-SR04 ultrasonic distance meter.
// Issues a trigger pulse on request, times the echo pulse in clk cycles and
// converts it to whole centimetres by counting CYC_PER_CM-cycle slices, so no
// divider is needed. The result saturates at DIST_MAX and holds between updates.
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   start       one-cycle measurement request, honoured only when idle
//   echo        raw sensor echo pin (asynchronous)
//   trig        sensor trigger output
//   distance    last valid distance in cm
//   dist_valid  one-cycle pulse when distance updates
//   busy        high whenever a measurement or holdoff is in progress
//   err         set on an echo timeout, cleared by the next good measurement
module sr04_distance_meter
  import sr04_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int TRIG_US     = DEF_TRIG_US,
  parameter int CM_US       = DEF_CM_US,
  parameter int TIMEOUT_US  = DEF_TIMEOUT_US,
  parameter int HOLDOFF_US  = DEF_HOLDOFF_US,
  parameter int DIST_MAX    = DEF_DIST_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              dist_valid,
  output logic              busy,
  output logic              err
);

  localparam int P_CYC_PER_US = CLK_FREQ_HZ / 1_000_000;

  // Terminal values: each phase ends on the edge where its counter reads LAST.
  localparam logic [CNT_W-1:0]  TRIG_LAST    = CNT_W'(TRIG_US * P_CYC_PER_US - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_US * P_CYC_PER_US - 1);
  localparam logic [CNT_W-1:0]  HOLDOFF_LAST = CNT_W'(HOLDOFF_US * P_CYC_PER_US - 1);
  localparam logic [CM_W-1:0]   CM_LAST      = CM_W'(CM_US * P_CYC_PER_US - 1);
  localparam logic [DIST_W-1:0] DIST_SAT     = DIST_W'(DIST_MAX);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              timeout_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CM_W-1:0]   sub_r;
  logic [DIST_W-1:0] acc_r;
  logic              echo_rise_s;
  logic              echo_fall_s;
  logic              echo_level_unused_s;

  // The FSM works purely on edges; the synchronised level is not needed here.
  echo_sync u_echo_sync (
    .clk       (clk),
    .rst       (rst),
    .echo      (echo),
    .echo_s    (echo_level_unused_s),
    .echo_rise (echo_rise_s),
    .echo_fall (echo_fall_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; an echo fall is tested before the timeout so it wins a tie.
  always_comb begin
    state_nxt_s = state_r;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_TRIG;
        else       state_nxt_s = ST_IDLE;
      end
      ST_TRIG: begin
        if (cnt_r == TRIG_LAST) state_nxt_s = ST_WAIT_ECHO;
        else                    state_nxt_s = ST_TRIG;
      end
      ST_WAIT_ECHO: begin
        if (echo_rise_s) begin
          state_nxt_s = ST_MEASURE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_nxt_s = ST_HOLDOFF;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_ECHO;
        end
      end
      ST_MEASURE: begin
        if (echo_fall_s) begin
          state_nxt_s = ST_DONE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_nxt_s = ST_HOLDOFF;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = ST_MEASURE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (cnt_r == HOLDOFF_LAST) state_nxt_s = ST_IDLE;
        else                       state_nxt_s = ST_HOLDOFF;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Phase cycle counter: restarts on every state change, idles at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_nxt_s != state_r) || (state_r == ST_IDLE)) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Centimetre slicer: every MEASURE cycle, including the one that sees the
  // fall, advances the slice counter so the result is floor(cycles/CYC_PER_CM).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_r <= {CM_W{1'b0}};
      acc_r <= {DIST_W{1'b0}};
    end else if (state_r == ST_WAIT_ECHO) begin
      sub_r <= {CM_W{1'b0}};
      acc_r <= {DIST_W{1'b0}};
    end else if (state_r == ST_MEASURE) begin
      if (sub_r == CM_LAST) begin
        sub_r <= {CM_W{1'b0}};
        if (acc_r < DIST_SAT) acc_r <= acc_r + DIST_W'(1);
      end else begin
        sub_r <= sub_r + CM_W'(1);
      end
    end
  end

  // Registered outputs; trig and busy follow the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig       <= 1'b0;
      busy       <= 1'b0;
      dist_valid <= 1'b0;
      distance   <= {DIST_W{1'b0}};
      err        <= 1'b0;
    end else begin
      trig       <= (state_nxt_s == ST_TRIG);
      busy       <= (state_nxt_s != ST_IDLE);
      dist_valid <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        distance <= acc_r;
        err      <= 1'b0;
      end else if (timeout_s) begin
        err <= 1'b1;
      end
    end
  end

endmodule
